// File: rtl/mesi_lru_cache_ctrl_if.sv
// Request/response bundle between the L1 trace driver / FSB model and the
// MESI + true-LRU tag controller. The controller takes the slave modport.
interface mesi_lru_cache_ctrl_if #(
  parameter int WAYS      = 8,
  parameter int ADDR_BITS = 32
);
  localparam int WAY_BITS = $clog2(WAYS);

  logic                 reqValid;
  logic                 reqReady;
  logic [2:0]           reqCmd;
  logic [ADDR_BITS-1:0] reqAddr;
  logic                 reqShared;
  logic                 respValid;
  logic                 respHit;
  logic [WAY_BITS-1:0]  respWay;
  logic [1:0]           respState;
  logic [2:0]           busOp;
  logic [1:0]           snoopResult;
  logic                 evictDirty;
  logic [ADDR_BITS-1:0] victimAddr;
  logic [31:0]          hitCount;
  logic [31:0]          missCount;

  modport slave (
    input  reqValid, reqCmd, reqAddr, reqShared,
    output reqReady, respValid, respHit, respWay, respState, busOp,
           snoopResult, evictDirty, victimAddr, hitCount, missCount
  );

  modport master (
    output reqValid, reqCmd, reqAddr, reqShared,
    input  reqReady, respValid, respHit, respWay, respState, busOp,
           snoopResult, evictDirty, victimAddr, hitCount, missCount
  );
endinterface

// File: rtl/mesi_lru_cache_ctrl.sv
// N-way set-associative tag/state store with MESI coherence, true-LRU replacement
// and snoop handling (CLEAR -> IDLE -> LOOKUP -> RESPOND). Define STATS_EN for hit/miss counters.
module mesi_lru_cache_ctrl #(
  parameter int WAYS        = 8,
  parameter int INDEX_BITS  = 14,
  parameter int TAG_BITS    = 12,
  parameter int OFFSET_BITS = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  mesi_lru_cache_ctrl_if.slave bus
);
  localparam int ADDR_BITS = TAG_BITS + INDEX_BITS + OFFSET_BITS;
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int SETS      = 2**INDEX_BITS;

  localparam logic [2:0] CMD_RD      = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_SNP_RD  = 3'd2;
  localparam logic [2:0] CMD_SNP_INV = 3'd3;
  localparam logic [2:0] CMD_SNP_RFO = 3'd4;
  localparam logic [2:0] CMD_CLR     = 3'd5;

  typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3} mesi_e;
  typedef enum logic [2:0] {BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_RFO = 3'd2,
                            BUS_INV = 3'd3, BUS_WB = 3'd4} bus_op_e;
  typedef enum logic [1:0] {SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2} snoop_e;
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_RESPOND} fsm_e;

  typedef logic [WAYS-1:0][TAG_BITS-1:0] tag_row_t;
  typedef logic [WAYS-1:0][1:0]          state_row_t;
  typedef logic [WAYS-1:0][WAY_BITS-1:0] age_row_t;

  tag_row_t   r_tag_mem   [SETS];
  state_row_t r_state_mem [SETS];
  age_row_t   r_age_mem   [SETS];

  fsm_e                  r_state, w_next_state;
  logic [INDEX_BITS-1:0] r_clr_idx;
  logic                  r_clear_all;
  logic [2:0]            r_cmd;
  logic [TAG_BITS-1:0]   r_tag;
  logic [INDEX_BITS-1:0] r_idx;
  logic                  r_shared;

  tag_row_t   r_new_tags;
  state_row_t r_new_states;
  age_row_t   r_new_ages;
  logic       r_wr_en;

  logic                 r_resp_hit;
  logic [WAY_BITS-1:0]  r_resp_way;
  logic [1:0]           r_resp_state;
  logic [2:0]           r_bus_op;
  logic [1:0]           r_snoop;
  logic                 r_evict;
  logic [ADDR_BITS-1:0] r_victim;

  tag_row_t   w_tags;
  state_row_t w_states;
  age_row_t   w_ages;
  age_row_t   w_init_ages;
  logic                w_hit, w_has_inv;
  logic [WAY_BITS-1:0] w_hit_way, w_inv_way, w_lru_way, w_way;
  logic [1:0]          w_old_state, w_new_state;
  logic                w_resp_hit, w_alloc, w_lru, w_wr, w_evict;
  bus_op_e             w_bus_op;
  snoop_e              w_snoop;
  logic [ADDR_BITS-1:0] w_victim;
  tag_row_t   w_row_tags;
  state_row_t w_row_states;
  age_row_t   w_row_ages;
  logic       w_accept, w_unused_offset;

  assign w_accept        = (r_state == S_IDLE) && bus.reqValid;
  assign w_unused_offset = ^bus.reqAddr[OFFSET_BITS-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_CLEAR:   if (&r_clr_idx) w_next_state = r_clear_all ? S_RESPOND : S_IDLE;
      S_IDLE:    if (bus.reqValid) w_next_state = (bus.reqCmd == CMD_CLR) ? S_CLEAR : S_LOOKUP;
      S_LOOKUP:  w_next_state = S_RESPOND;
      S_RESPOND: w_next_state = S_IDLE;
      default:   w_next_state = S_CLEAR;
    endcase
  end

  assign w_tags   = r_tag_mem[r_idx];
  assign w_states = r_state_mem[r_idx];
  assign w_ages   = r_age_mem[r_idx];

  // Descending scan so the lowest-index match wins for the invalid-way search.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_has_inv   = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    w_init_ages = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      w_init_ages[w] = WAY_BITS'(w);
      if (w_states[w] != ST_I && w_tags[w] == r_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
      if (w_states[w] == ST_I) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_BITS'(w);
      end
      if (w_ages[w] == WAY_BITS'(WAYS-1)) w_lru_way = WAY_BITS'(w);
    end
  end

  assign w_old_state = w_states[w_hit_way];

  always_comb begin
    w_resp_hit  = w_hit;
    w_new_state = w_hit ? w_old_state : ST_I;
    w_bus_op    = BUS_NONE;
    w_snoop     = SNP_NOHIT;
    w_alloc     = 1'b0;
    w_lru       = 1'b0;
    w_wr        = 1'b0;
    case (r_cmd)
      CMD_RD: begin
        w_lru = 1'b1;
        w_wr  = 1'b1;
        if (!w_hit) begin
          w_alloc     = 1'b1;
          w_bus_op    = BUS_READ;
          w_new_state = r_shared ? ST_S : ST_E;
        end
      end
      CMD_WR: begin
        w_lru       = 1'b1;
        w_wr        = 1'b1;
        w_new_state = ST_M;
        if (!w_hit) begin
          w_alloc  = 1'b1;
          w_bus_op = BUS_RFO;
        end else if (w_old_state == ST_S) begin
          w_bus_op = BUS_INV;
        end
      end
      CMD_SNP_RD, CMD_SNP_RFO: begin
        if (w_hit) begin
          w_wr        = 1'b1;
          w_new_state = (r_cmd == CMD_SNP_RD) ? ST_S : ST_I;
          w_snoop     = (w_old_state == ST_M) ? SNP_HITM : SNP_HIT;
          w_bus_op    = (w_old_state == ST_M) ? BUS_WB : BUS_NONE;
        end
      end
      CMD_SNP_INV: begin
        // M/E lines ignore an invalidate: the requester broke protocol.
        if (w_hit && w_old_state == ST_S) begin
          w_wr        = 1'b1;
          w_new_state = ST_I;
          w_snoop     = SNP_HIT;
        end
      end
      default: begin
        w_resp_hit  = 1'b0;
        w_new_state = ST_I;
      end
    endcase
  end

  always_comb begin
    w_way = w_hit_way;
    if (w_alloc) w_way = w_has_inv ? w_inv_way : w_lru_way;
    else if (!w_hit) w_way = '0;
  end

  assign w_evict  = w_alloc && (w_states[w_way] == ST_M);
  assign w_victim = w_evict ? {w_tags[w_way], r_idx, {OFFSET_BITS{1'b0}}} : '0;

  always_comb begin
    w_row_tags          = w_tags;
    w_row_states        = w_states;
    w_row_ages          = w_ages;
    w_row_tags[w_way]   = r_tag;
    w_row_states[w_way] = w_new_state;
    if (w_lru) begin
      for (int w = 0; w < WAYS; w++)
        if (w_ages[w] < w_ages[w_way]) w_row_ages[w] = w_ages[w] + 1'b1;
      w_row_ages[w_way] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_idx    <= '0;
      r_clear_all  <= 1'b0;
      r_cmd        <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_shared     <= 1'b0;
      r_new_tags   <= '0;
      r_new_states <= '0;
      r_new_ages   <= '0;
      r_wr_en      <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      r_resp_state <= '0;
      r_bus_op     <= '0;
      r_snoop      <= '0;
      r_evict      <= 1'b0;
      r_victim     <= '0;
    end else begin
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
      if (w_accept) begin
        r_cmd       <= bus.reqCmd;
        r_tag       <= bus.reqAddr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
        r_idx       <= bus.reqAddr[OFFSET_BITS +: INDEX_BITS];
        r_shared    <= bus.reqShared;
        r_clear_all <= (bus.reqCmd == CMD_CLR);
      end
      if (r_state == S_LOOKUP) begin
        r_new_tags   <= w_row_tags;
        r_new_states <= w_row_states;
        r_new_ages   <= w_row_ages;
        r_wr_en      <= w_wr;
        r_resp_hit   <= w_resp_hit;
        r_resp_way   <= w_way;
        r_resp_state <= w_new_state;
        r_bus_op     <= w_bus_op;
        r_snoop      <= w_snoop;
        r_evict      <= w_evict;
        r_victim     <= w_victim;
      end
      // A clear-all completion reports an all-zero result.
      if (r_state == S_CLEAR && (&r_clr_idx) && r_clear_all) begin
        r_wr_en      <= 1'b0;
        r_resp_hit   <= 1'b0;
        r_resp_way   <= '0;
        r_resp_state <= '0;
        r_bus_op     <= '0;
        r_snoop      <= '0;
        r_evict      <= 1'b0;
        r_victim     <= '0;
      end
    end
  end

  // NOTE: the arrays have no reset branch; the CLEAR sweep initialises them so they map onto RAM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        r_tag_mem[r_clr_idx]   <= '0;
        r_state_mem[r_clr_idx] <= '0;
        r_age_mem[r_clr_idx]   <= w_init_ages;
      end else if (r_state == S_RESPOND && r_wr_en) begin
        r_tag_mem[r_idx]   <= r_new_tags;
        r_state_mem[r_idx] <= r_new_states;
        r_age_mem[r_idx]   <= r_new_ages;
      end
    end
  end

`ifdef STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clock) begin
    if (reset || (w_accept && bus.reqCmd == CMD_CLR)) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_RESPOND && (r_cmd == CMD_RD || r_cmd == CMD_WR)) begin
      if (r_resp_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign bus.hitCount  = r_hit_cnt;
  assign bus.missCount = r_miss_cnt;
`else
  assign bus.hitCount  = '0;
  assign bus.missCount = '0;
`endif

  assign bus.reqReady    = (r_state == S_IDLE);
  assign bus.respValid   = (r_state == S_RESPOND);
  assign bus.respHit     = r_resp_hit;
  assign bus.respWay     = r_resp_way;
  assign bus.respState   = r_resp_state;
  assign bus.busOp       = r_bus_op;
  assign bus.snoopResult = r_snoop;
  assign bus.evictDirty  = r_evict;
  assign bus.victimAddr  = r_victim;
endmodule

// File: tb/tb_mesi_lru_cache_ctrl.sv
// Scoreboard bench for mesi_lru_cache_ctrl: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever respValid is seen.
module tb_mesi_lru_cache_ctrl;
  localparam int WAYS = 8, INDEX_BITS = 4, TAG_BITS = 12, OFFSET_BITS = 6;
  localparam int AB = TAG_BITS + INDEX_BITS + OFFSET_BITS;
  localparam int WB = $clog2(WAYS);

  localparam logic [2:0] RD = 3'd0, WR = 3'd1, SRD = 3'd2, SINV = 3'd3, SRFO = 3'd4, CLR = 3'd5;
  localparam logic [1:0] I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3;
  localparam logic [2:0] NONE = 3'd0, READ = 3'd1, RFO = 3'd2, INV = 3'd3, WB_OP = 3'd4;
  localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;

  typedef struct {
    string          name;
    int             lat;
    longint         hs;
    logic           hit;
    logic [WB-1:0]  way;
    logic [1:0]     st;
    logic [2:0]     op;
    logic [1:0]     snp;
    logic           ev;
    logic [AB-1:0]  va;
  } exp_t;

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  exp_t   q[$];
  exp_t   mon_e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mesi_lru_cache_ctrl_if #(.WAYS(WAYS), .ADDR_BITS(AB)) bus ();

  mesi_lru_cache_ctrl #(
    .WAYS(WAYS), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS), .OFFSET_BITS(OFFSET_BITS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (bus.respValid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected respValid", 64'd1, 64'd0);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, " latency"},   64'(cyc - mon_e.hs), 64'(mon_e.lat));
        check({mon_e.name, " respHit"},   64'(bus.respHit),     64'(mon_e.hit));
        check({mon_e.name, " respWay"},   64'(bus.respWay),     64'(mon_e.way));
        check({mon_e.name, " respState"}, 64'(bus.respState),   64'(mon_e.st));
        check({mon_e.name, " busOp"},     64'(bus.busOp),       64'(mon_e.op));
        check({mon_e.name, " snoop"},     64'(bus.snoopResult), 64'(mon_e.snp));
        check({mon_e.name, " evict"},     64'(bus.evictDirty),  64'(mon_e.ev));
        check({mon_e.name, " victim"},    64'(bus.victimAddr),  64'(mon_e.va));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input string name, input logic [2:0] cmd, input logic [AB-1:0] addr,
                      input logic sh, input int lat, input logic hit, input logic [WB-1:0] way,
                      input logic [1:0] st, input logic [2:0] op, input logic [1:0] snp,
                      input logic ev, input logic [AB-1:0] va);
    exp_t e;
    int   guard;
    guard = 0;
    while (bus.reqReady !== 1'b1 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) begin
      check({name, " reqReady timeout"}, 64'd0, 64'd1);
      return;
    end
    e.name = name; e.lat = lat; e.hs = cyc; e.hit = hit; e.way = way;
    e.st = st; e.op = op; e.snp = snp; e.ev = ev; e.va = va;
    q.push_back(e);
    bus.reqValid  = 1'b1;
    bus.reqCmd    = cmd;
    bus.reqAddr   = addr;
    bus.reqShared = sh;
    @(negedge clock);
    bus.reqValid  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (q.size() != 0) begin
      check("drain timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clock);
  endtask

  task automatic check_stats(input string name, input int hits, input int misses);
`ifdef STATS_EN
    check({name, " hitCount"},  64'(bus.hitCount),  64'(hits));
    check({name, " missCount"}, 64'(bus.missCount), 64'(misses));
`else
    check({name, " hitCount"},  64'(bus.hitCount),  64'(hits * 0));
    check({name, " missCount"}, 64'(bus.missCount), 64'(misses * 0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AB-1:0] a;
    logic [AB-1:0] addr;
    int            n0;
    a = AB'(32'h0001_0040);
    bus.reqValid = 1'b0; bus.reqCmd = '0; bus.reqAddr = '0; bus.reqShared = 1'b0;

    // Reset held across exactly one rising edge, then count the CLEAR sweep.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("reset respValid",  64'(bus.respValid),  64'd0);
    check("reset busOp",      64'(bus.busOp),      64'd0);
    check("reset respHit",    64'(bus.respHit),    64'd0);
    check("reset victimAddr", 64'(bus.victimAddr), 64'd0);
    check_stats("reset", 0, 0);
    n0 = 0;
    while (bus.reqReady !== 1'b1 && n0 < 100) begin
      n0++;
      @(negedge clock);
    end
    check("clear sweep cycles", 64'(n0), 64'd16);

    // Basic MESI transitions on one line (tag 0x40, set 1).
    send("rd miss",  RD,  a, 1'b0, 2, 1'b0, 3'd0, E, READ,  NOHIT, 1'b0, '0);
    send("rd hit",   RD,  a, 1'b0, 2, 1'b1, 3'd0, E, NONE,  NOHIT, 1'b0, '0);
    send("wr hit E", WR,  a, 1'b0, 2, 1'b1, 3'd0, M, NONE,  NOHIT, 1'b0, '0);
    send("snp rd M", SRD, a, 1'b0, 2, 1'b1, 3'd0, S, WB_OP, HITM,  1'b0, '0);
    send("wr hit S", WR,  a, 1'b0, 2, 1'b1, 3'd0, M, INV,   NOHIT, 1'b0, '0);

    // Nine write misses to set 2: the ninth evicts the LRU way 0 (tag 1, dirty).
    for (int t = 1; t <= 9; t++) begin
      addr = AB'((t << 10) | (2 << 6) | ((t == 1) ? 'h15 : 0));
      if (t <= 8) send($sformatf("wr fill %0d", t), WR, addr, 1'b0, 2, 1'b0, WB'(t - 1), M, RFO,
                       NOHIT, 1'b0, '0);
      else        send("wr evict", WR, addr, 1'b0, 2, 1'b0, 3'd0, M, RFO, NOHIT, 1'b1, AB'('h480));
    end

    // Snoops and shared read allocation on set 2.
    send("snp rfo M",    SRFO, AB'('h880), 1'b0, 2, 1'b1, 3'd1, I, WB_OP, HITM,  1'b0, '0);
    send("snp rfo miss", SRFO, AB'('h880), 1'b0, 2, 1'b0, 3'd0, I, NONE,  NOHIT, 1'b0, '0);
    send("rd miss shr",  RD,   AB'('h880), 1'b1, 2, 1'b0, 3'd1, S, READ,  NOHIT, 1'b0, '0);
    send("snp inv S",    SINV, AB'('h880), 1'b0, 2, 1'b1, 3'd1, I, NONE,  HIT,   1'b0, '0);
    send("snp inv M",    SINV, AB'('hC80), 1'b0, 2, 1'b1, 3'd2, M, NONE,  NOHIT, 1'b0, '0);
    send("reserved",     3'd6, a,          1'b0, 2, 1'b0, 3'd0, I, NONE,  NOHIT, 1'b0, '0);
    send("snp rd miss",  SRD,  AB'('h0C0), 1'b0, 2, 1'b0, 3'd0, I, NONE,  NOHIT, 1'b0, '0);
    drain();
    check_stats("after fills", 3, 11);

    // Reset asserted during RESPOND aborts the request and restarts CLEAR.
    send("rd hit pre-rst", RD, a, 1'b0, 2, 1'b1, 3'd0, M, NONE, NOHIT, 1'b0, '0);
    @(negedge clock);
    check("in RESPOND before reset", 64'(bus.respValid), 64'd1);
    #1 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("respValid after mid reset", 64'(bus.respValid), 64'd0);
    check("reqReady after mid reset",  64'(bus.reqReady),  64'd0);
    check_stats("after mid reset", 0, 0);
    send("rd after reset", RD, a, 1'b0, 2, 1'b0, 3'd0, E, READ, NOHIT, 1'b0, '0);
    send("rd hit again",   RD, a, 1'b0, 2, 1'b1, 3'd0, E, NONE, NOHIT, 1'b0, '0);
    drain();
    check_stats("post reset", 1, 1);

    // Clear-all: one pulse after the 16-set sweep, counters zeroed, line gone.
    send("clear all", CLR, '0, 1'b0, 17, 1'b0, 3'd0, I, NONE, NOHIT, 1'b0, '0);
    drain();
    check_stats("after clear-all", 0, 0);
    send("rd after clear", RD, a, 1'b0, 2, 1'b0, 3'd0, E, READ, NOHIT, 1'b0, '0);
    drain();
    repeat (3) @(negedge clock);
    check("busOp held", 64'(bus.busOp), 64'(READ));
    check_stats("final", 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mesi_lru_cache_ctrl.md
Name: mesi_lru_cache_ctrl

Overview:
Parametrised, clocked successor to the team's combinational L2 cache model. Implements an N-way set-associative tag/state store with MESI coherence, true-LRU replacement and bus-snoop handling. Holds tags and state only, no data payload. Sits between the L1 request stream (trace-driven) and the shared FSB. Emits bus operations and snoop results.

Parameters:
WAYS, 8, associativity; power of 2, at least 2
INDEX_BITS, 14, set index width; sets = 2**INDEX_BITS
TAG_BITS, 12, tag width
OFFSET_BITS, 6, byte offset width (64-byte line); ADDR_BITS = TAG_BITS+INDEX_BITS+OFFSET_BITS

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
reqValid  in  1  request present
reqReady  out  1  block can accept a request
reqCmd  in  3  0 L1 read, 1 L1 write, 2 snoop read, 3 snoop invalidate, 4 snoop RFO, 5 clear all; 6-7 reserved
reqAddr  in  ADDR_BITS  request address
reqShared  in  1  another cache holds the line (used on L1 read miss)
respValid  out  1  one-cycle pulse with results
respHit  out  1  tag match on a non-I way
respWay  out  log2(WAYS)  way hit or allocated
respState  out  2  new MESI state: 0 I, 1 S, 2 E, 3 M
busOp  out  3  0 NONE, 1 READ, 2 RFO, 3 INVALIDATE, 4 WRITEBACK
snoopResult  out  2  0 NOHIT, 1 HIT, 2 HITM
evictDirty  out  1  allocated victim was M
victimAddr  out  ADDR_BITS  victim line address, offset bits 0
hitCount, missCount  out  32  statistics (see Optional Feature)

Behaviour:
- Reset and state after reset: all outputs 0 and reqReady 0. FSM enters CLEAR.
- Reset at any point, including mid-request, aborts the request with no respValid and restarts CLEAR at set 0.
- FSM states and transitions:
  - CLEAR: one set per cycle, sets 0..2**INDEX_BITS-1. Every way state=I, tag=0, age[w]=w. Then goes to IDLE.
  - IDLE: reqReady=1. Handshake is reqValid&&reqReady at edge T; addr/cmd/shared are latched. Goes to LOOKUP.
  - LOOKUP (T+1): read set, compare tags, select way. Goes to RESPOND.
  - RESPOND (T+2): respValid=1 and all result outputs valid for this cycle only. Array writes commit at the end of this cycle. Goes to IDLE.
  - Throughput is one request per 3 cycles. reqReady is 0 outside IDLE.
- Output hold rule: result outputs other than respValid hold their value until the next RESPOND.
- Victim selection on a miss allocation: lowest-index way in state I; otherwise the way with age==WAYS-1.
- LRU update (L1 read and L1 write only): the accessed way's age goes to 0. Every way whose age was below the accessed way's old age increments. Snoops never change ages.
- L1 read:
  - Hit: state unchanged, busOp NONE.
  - Miss: allocate; busOp READ; state S if reqShared, else E.
- L1 write:
  - Hit on M or E: state becomes M, busOp NONE.
  - Hit on S: state becomes M, busOp INVALIDATE.
  - Miss: allocate, busOp RFO, state M.
- Any allocation whose victim is M: evictDirty=1 and victimAddr=victim tag and index. busOp still reports READ or RFO.
- Snoop read:
  - M: becomes S; snoopResult HITM; busOp WRITEBACK.
  - E or S: becomes S; snoopResult HIT.
  - I or miss: NOHIT.
- Snoop RFO:
  - M: becomes I; HITM; busOp WRITEBACK.
  - E or S: becomes I; HIT.
- Snoop invalidate:
  - S: becomes I; HIT.
  - M or E: state unchanged; NOHIT (protocol violation, ignored).
- snoopResult is NOHIT for L1 commands.
- respHit is 1 for snoops that match a non-I way.
- Clear-all: accepted like a normal request, then behaves as CLEAR. respValid pulses once when the sweep completes.
- Reserved commands: respValid pulses with all results 0 and no state change.

Optional Feature:
STATS_EN defined:
- hitCount/missCount increment in RESPOND for L1 read/write hit/miss.
- Both saturate at 32'hFFFF_FFFF.
- Both are zeroed by reset and by clear-all.
STATS_EN undefined:
- No counters are implemented.
- Ports remain and are driven constant 0.

Test Plan:
1. INDEX_BITS=4, reset high 1 cycle -> reqReady 0 for exactly 16 cycles, then 1.
2. L1 read 0x0001_0040, reqShared=0 -> respValid at T+2, respHit=0, busOp READ, respState E, respWay 0. Repeat -> respHit=1, busOp NONE, state E.
3. L1 write same address -> hit, state M. Then snoop read same address -> snoopResult HITM, busOp WRITEBACK, state S.
4. Write hit on that S line -> busOp INVALIDATE, state M.
5. WAYS=8: L1 writes to 9 distinct tags in one set -> the 9th selects way 0 (LRU), evictDirty=1, victimAddr = first address with offset cleared, busOp RFO.
6. Assert reset during RESPOND -> respValid 0 the next cycle, CLEAR restarts. A following read of the earlier address -> miss. With STATS_EN, hitCount 0.
